// File: rtl/req_enc_pkg.sv
// Shared definitions for the 16-line request encoder.
// Contents:
//   NUM_REQ, CODE_W : number of request lines and the width of their index
//   req_vec_t       : 16-bit request / pending vector
//   code_t          : 4-bit encoded index
//   popcount16      : number of set bits in a req_vec_t (0..16)
package req_enc_pkg;

  localparam int NUM_REQ = 16;
  localparam int CODE_W  = $clog2(NUM_REQ);

  typedef logic [15:0] req_vec_t;
  typedef logic [3:0]  code_t;

  function automatic logic [4:0] popcount16(input req_vec_t v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n = n + {4'b0000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational 16-input priority encoder with a movable starting point.
// The search begins at bit 'start' and proceeds upward, wrapping from 15
// back to 0; the first set bit found is reported.
// Ports:
//   vec   in  16  candidate vector
//   start in  4   index searched first
//   idx   out 4   index of the first set bit at or after start (mod 16)
//   found out 1   vec has at least one bit set; idx is meaningless otherwise
module prio_enc16 (
  input  logic [15:0] vec,
  input  logic [3:0]  start,
  output logic [3:0]  idx,
  output logic        found
);
  import req_enc_pkg::*;

  // Two copies side by side let a plain part-select perform the rotation.
  logic [30:0] dbl;
  logic [15:0] rot;
  code_t       off;

  always_comb begin
    dbl   = {vec[14:0], vec};
    rot   = dbl[start +: 16];
    off   = '0;
    // Scan downward so the lowest set bit of the rotated vector wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = code_t'(i);
    end
    found = |vec;
    idx   = start + off;
  end

endmodule

// File: rtl/req_encoder_16x4.sv
// Sequential one-hot-to-binary request encoder.
// Sticky request lines are collected in a pending register; one pending
// request at a time is selected and offered as a 4-bit code on a
// valid/ready channel. The selected bit leaves pending at the edge it is
// loaded, unless its request line is high at that same edge (set wins).
// Selection is lowest-index-first by default. Defining
// REQ_ENCODER_ROUND_ROBIN_EN switches to round-robin, starting the search
// one past the most recently loaded index.
// Ports:
//   clk         in  1   rising-edge clock
//   rst         in  1   asynchronous active-high reset
//   req         in  16  level request lines, sampled every edge
//   code        out 4   index of the offered request
//   valid       out 1   code is meaningful
//   ready       in  1   consumer takes code when valid & ready at an edge
//   pending_cnt out 5   number of pending requests, excluding the offered one
module req_encoder_16x4 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic [3:0]  code,
  output logic        valid,
  input  logic        ready,
  output logic [4:0]  pending_cnt
);
  import req_enc_pkg::*;

  req_vec_t pending_q, pending_d;
  code_t    code_q, code_d;
  logic     valid_q, valid_d;

  code_t    start;
  code_t    sel_idx;
  logic     sel_found;
  logic     slot_free;
  logic     load;
  req_vec_t take;

  prio_enc16 u_prio (
    .vec   (pending_q),
    .start (start),
    .idx   (sel_idx),
    .found (sel_found)
  );

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  code_t ptr_q, ptr_d;

  assign start = ptr_q + 4'd1;

  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = sel_idx;
  end

  // Reset to 15 so the very first search begins at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 4'd15;
    else     ptr_q <= ptr_d;
  end
`else
  assign start = '0;
`endif

  always_comb begin
    slot_free = ~valid_q | ready;
    load      = slot_free & sel_found;
    take      = load ? (req_vec_t'(1) << sel_idx) : '0;
    pending_d = (pending_q & ~take) | req;

    code_d  = code_q;
    valid_d = valid_q;
    if (slot_free) begin
      valid_d = load;
      if (load) code_d = sel_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

  assign code        = code_q;
  assign valid       = valid_q;
  assign pending_cnt = popcount16(pending_q);

endmodule

// File: tb/tb_req_encoder_16x4.sv
// Self-checking bench for req_encoder_16x4: a behavioural model of the
// pending set predicts each offered code into a queue; a negedge monitor
// pops and compares whenever the DUT presents a new offer.
module tb_req_encoder_16x4;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [3:0]  code;
  logic        valid;
  logic        ready;
  logic [4:0]  pending_cnt;

  int checks = 0;
  int errors = 0;

  req_encoder_16x4 dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .code        (code),
    .valid       (valid),
    .ready       (ready),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending events kept as a set of 16 flags; the output slot holds one
  // event. Every edge: if the slot is empty or being consumed, the next
  // event is chosen by scanning the set from the priority start point.
  bit [15:0] m_pend;
  bit        m_valid;
  int        m_last;
  int        exp_q[$];

  always @(posedge clk or posedge rst) begin
    int first;
    int pick;
    if (rst) begin
      m_pend  = '0;
      m_valid = 0;
      m_last  = 15;
      exp_q.delete();
    end else begin
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
      first = (m_last + 1) % 16;
`else
      first = 0;
`endif
      if (!m_valid || ready) begin
        pick = -1;
        for (int k = 0; k < 16; k++) begin
          if (pick < 0 && m_pend[(first + k) % 16]) pick = (first + k) % 16;
        end
        if (pick >= 0) begin
          m_pend[pick] = 1'b0;
          m_valid      = 1;
          m_last       = pick;
          exp_q.push_back(pick);
        end else begin
          m_valid = 0;
        end
      end
      m_pend = m_pend | req;
    end
  end

  // ---------------- monitor ----------------
  bit prev_valid = 0;
  bit prev_ready = 0;
  int cur_code   = 0;

  always @(negedge clk) begin
    if (!rst) begin
      check("valid", int'(valid), int'(m_valid));
      check("pending_cnt", int'(pending_cnt), $countones(m_pend));
      if (valid) begin
        if (!prev_valid || prev_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL code_unexpected: got %0d, expected no offer (t=%0t)", code, $time);
          end else begin
            cur_code = exp_q.pop_front();
            check("code", int'(code), cur_code);
          end
        end else begin
          check("code_hold", int'(code), cur_code);
        end
      end
      prev_valid = valid;
      prev_ready = ready;
    end else begin
      prev_valid = 0;
      prev_ready = 0;
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 1 time unit after a rising edge and apply to the next edge.
  task automatic drive(input logic [15:0] r, input logic rd);
    @(posedge clk);
    #1;
    req   = r;
    ready = rd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'h0000, 1'b1);
  endtask

  initial begin
    rst   = 1'b1;
    req   = 16'h0000;
    ready = 1'b0;
    #1;
    check("reset_valid", int'(valid), 0);
    check("reset_code", int'(code), 0);
    check("reset_cnt", int'(pending_cnt), 0);
    // Requests during reset must be ignored.
    drive(16'hFFFF, 1'b1);
    drive(16'hFFFF, 1'b1);
    req = 16'h0000;
    rst = 1'b0;
    idle(3);

    // Single event.
    drive(16'h0001, 1'b1);
    idle(4);

    // Multiple events in one pulse.
    drive(16'h8421, 1'b1);
    idle(6);

    // Backpressure, then release.
    drive(16'h0006, 1'b0);
    drive(16'h0000, 1'b0);
    for (int i = 0; i < 6; i++) drive(16'h0000, 1'b0);
    idle(5);

    // Set wins over clear: req[3] held across its load edge.
    drive(16'h0008, 1'b1);
    drive(16'h0008, 1'b1);
    drive(16'h0008, 1'b1);
    idle(5);

    // Two lines held continuously.
    for (int i = 0; i < 8; i++) drive(16'h0003, 1'b1);
    idle(5);

    // Asynchronous reset mid-stream with pending=0x00F0 and valid=1.
    drive(16'h00F1, 1'b0);
    drive(16'h0000, 1'b0);
    drive(16'h0000, 1'b0);
    drive(16'h0000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(valid), 0);
    check("async_rst_code", int'(code), 0);
    check("async_rst_cnt", int'(pending_cnt), 0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ready = 1'b1;
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] r;
      logic        rd;
      r  = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom) : 16'h0000;
      if ($urandom_range(0, 15) == 0) r = 16'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      drive(r, rd);
    end

    // Drain; every predicted offer must have been observed.
    idle(40);
    @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_encoder_16x4.md
Name: req_encoder_16x4

Overview:
- Sequential one-hot-to-binary encoder; the inverse of the team's 4-to-16 decoder.
- Captures 16 sticky request lines into a pending register.
- Selects one pending request by priority and presents its 4-bit index on a valid/ready output channel.
- Sits between request sources (interrupt/event lines) and a consumer that drives the 4x16 decoder with the returned code.

Parameters:
- NUM_REQ, 16, number of request lines; fixed at 16 for this revision.
- CODE_W, 4, width of encoded index; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  level request lines, sampled every rising edge; bit i high = event i.
- code  output  4  binary index of the offered request.
- valid  output  1  code is meaningful.
- ready  input  1  consumer accepts code when valid & ready at a rising edge.
- pending_cnt  output  5  popcount of the pending register (0..16).

Behaviour:
- Reset (async, rst high, no clock needed): pending=0, valid=0, code=0, pending_cnt=0. All state holds reset while rst stays high; req is ignored.
- Pending register, per bit i, next = (pending[i] & ~take[i]) | req[i]. Set wins over clear.
  - take = one-hot of the selected index, and only when load occurs.
- slot_free = ~valid | ready.
- load = slot_free & (pending != 0).
- On load:
  - code <= selected index;
  - valid <= 1;
  - the selected bit is moved out of pending at the same edge.
- slot_free with pending == 0: valid <= 0; code holds its last value.
- valid & ~ready: code and valid hold; no load.
- Selection is fixed priority, lowest index wins (bit 0 highest).
- Latency: req high in cycle 0 → pending bit set after edge 1 → valid/code after edge 2. With ready held high, throughput is one code per cycle.
- Selection uses the registered pending only; req sampled at the same edge is never offered before it is in pending.
- Duplicate events: req[i] held high while i is pending merges into one event. If req[i] is high at the edge where i is loaded, i stays pending and is offered again later (new event).
- pending_cnt is combinational popcount of the pending register. It excludes the request currently held in the output slot.
- code always lies in 0..15. No out-of-range encoding exists.

Optional Feature:
- Macro: REQ_ENCODER_ROUND_ROBIN_EN.
- Defined: round-robin priority. A last-granted pointer (4 bits, reset 15) updates on every load. Search starts at (pointer+1) mod 16 and wraps from 15 to 0.
- Undefined: fixed lowest-index priority as above; no pointer register.

Decomposition:
- Shared package req_enc_pkg:
  - NUM_REQ and CODE_W constants;
  - typedef req_vec_t [15:0];
  - typedef code_t [3:0];
  - function popcount16.
- One sub-module: prio_enc16. Combinational, input 16-bit vector plus 4-bit start index, outputs 4-bit index and found flag. The top ties start to 0 unless REQ_ENCODER_ROUND_ROBIN_EN is defined.

Test Plan:
- Reset: assert rst mid-stream with pending=0x00F0 and valid=1, no clock edge → valid=0, code=0, pending_cnt=0 immediately. Release → idle until next req.
- Single event: req=0x0001 for one cycle, ready=1 → exactly one cycle of valid=1, code=0, two edges after req; pending_cnt returns to 0.
- Multiple events: req=0x8421 for one cycle, ready=1 → codes 0, 5, 10, 15 on consecutive cycles. pending_cnt reads 4 then 3, 2, 1, 0.
- Backpressure: ready=0, req=0x0006 pulse → valid=1, code=1 held indefinitely, pending_cnt=1. Raise ready → code 1 accepted, then code 2, then valid=0.
- Set-wins: hold req[3]=1 across the edge where 3 is loaded, ready=1 → code 3 offered on two consecutive cycles; pending_cnt=1 between them.
- With REQ_ENCODER_ROUND_ROBIN_EN: req=0x0003 held high continuously, ready=1 → codes alternate 0, 1, 0, 1.
- Same case without the macro → code 0 every cycle; bit 1 is never served while bit 0 stays asserted.
